// File: rtl/milano_pkg.sv
// ============================================================================
// Module  : milano_pkg
// Brief   : Shared opcode, ALU/LSU operation encodings and decoded bundle type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package milano_pkg;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OP_IMM = 7'h13,
        OPCODE_AUIPC  = 7'h17,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_LUI    = 7'h37
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_opt_e;

    typedef enum logic [3:0] {
        LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
        LSU_SB, LSU_SH, LSU_SW
    } lsu_opt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic        rd_wr_en;
        logic        alu_sel;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        alu_opt_e    alu_op;
        logic        lsu_req;
        logic        lsu_we;
        lsu_opt_e    lsu_op;
        logic [31:0] lsu_wdata;
        logic        illegal;
    } decode_t;

    localparam decode_t C_DEC_RESET = '{
        pc: 32'h0, rd_addr: 5'h0, rd_wr_en: 1'b0, alu_sel: 1'b0,
        operand_a: 32'h0, operand_b: 32'h0, alu_op: ALU_NONE,
        lsu_req: 1'b0, lsu_we: 1'b0, lsu_op: LSU_NONE,
        lsu_wdata: 32'h0, illegal: 1'b0
    };

    // ALU_NONE marks an unlisted funct3/funct7 pairing. The immediate form
    // ignores funct7 except for the shift encodings.
    function automatic alu_opt_e alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic is_imm);
        alu_opt_e fn;
        fn = ALU_NONE;
        case (f3)
            3'b000: fn = (is_imm || f7 == 7'h00) ? ALU_ADD :
                         (f7 == 7'h20) ? ALU_SUB : ALU_NONE;
            3'b001: fn = (f7 == 7'h00) ? ALU_SLL : ALU_NONE;
            3'b010: fn = (is_imm || f7 == 7'h00) ? ALU_SLT : ALU_NONE;
            3'b011: fn = (is_imm || f7 == 7'h00) ? ALU_SLTU : ALU_NONE;
            3'b100: fn = (is_imm || f7 == 7'h00) ? ALU_XOR : ALU_NONE;
            3'b101: fn = (f7 == 7'h00) ? ALU_SRL :
                         (f7 == 7'h20) ? ALU_SRA : ALU_NONE;
            3'b110: fn = (is_imm || f7 == 7'h00) ? ALU_OR : ALU_NONE;
            default: fn = (is_imm || f7 == 7'h00) ? ALU_AND : ALU_NONE;
        endcase
        return fn;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module  : instr_fifo
// Brief   : DEPTH-entry {addr, instr} buffer with push/pop/flush and occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [63:0]                  wdata_i,
    output logic [63:0]                  rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (count_q == C_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module  : decode_stage
// Brief   : Buffered RV32I decode stage with bypass, back-pressure and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import milano_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    input  logic [31:0]                instr_rdata_i,
    input  logic [31:0]                instr_addr_i,
    output logic [4:0]                 rs1_addr_o,
    output logic [4:0]                 rs2_addr_o,
    input  logic [31:0]                rs1_rdata_i,
    input  logic [31:0]                rs2_rdata_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [31:0]                dec_pc_o,
    output logic [4:0]                 rd_addr_o,
    output logic                       rd_wr_en_o,
    output logic                       alu_sel_o,
    output logic [31:0]                operand_a_o,
    output logic [31:0]                operand_b_o,
    output alu_opt_e                   alu_operate_o,
    output logic                       lsu_req_o,
    output logic                       lsu_we_o,
    output lsu_opt_e                   lsu_operate_o,
    output logic [31:0]                lsu_wdata_o,
    output logic                       illegal_instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    function automatic decode_t decode_instr(input logic [31:0] instr, input logic [31:0] pc,
                                             input logic [31:0] rs1, input logic [31:0] rs2);
        decode_t     d;
        logic        legal;
        logic [31:0] imm_i, imm_s, imm_u;
        d     = C_DEC_RESET;
        legal = 1'b1;
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_u = {instr[31:12], 12'h000};
        d.pc  = pc;
        case (instr[6:0])
            OPCODE_OP, OPCODE_OP_IMM: begin
                d.alu_op    = alu_fn(instr[14:12], instr[31:25], instr[6:0] == OPCODE_OP_IMM);
                d.operand_a = rs1;
                d.operand_b = (instr[6:0] == OPCODE_OP) ? rs2 : imm_i;
                d.rd_addr   = instr[11:7];
                d.rd_wr_en  = 1'b1;
                d.alu_sel   = 1'b1;
                legal       = (d.alu_op != ALU_NONE);
            end
            OPCODE_LOAD: begin
                d.operand_a = rs1;
                d.operand_b = imm_i;
                d.alu_op    = ALU_ADD;
                d.lsu_req   = 1'b1;
                d.rd_addr   = instr[11:7];
                d.rd_wr_en  = 1'b1;
                case (instr[14:12])
                    3'b000:  d.lsu_op = LSU_LB;
                    3'b001:  d.lsu_op = LSU_LH;
                    3'b010:  d.lsu_op = LSU_LW;
                    3'b100:  d.lsu_op = LSU_LBU;
                    3'b101:  d.lsu_op = LSU_LHU;
                    default: legal    = 1'b0;
                endcase
            end
            OPCODE_STORE: begin
                d.operand_a = rs1;
                d.operand_b = imm_s;
                d.alu_op    = ALU_ADD;
                d.lsu_req   = 1'b1;
                d.lsu_we    = 1'b1;
                d.lsu_wdata = rs2;
                case (instr[14:12])
                    3'b000:  d.lsu_op = LSU_SB;
                    3'b001:  d.lsu_op = LSU_SH;
                    3'b010:  d.lsu_op = LSU_SW;
                    default: legal    = 1'b0;
                endcase
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                d.operand_a = (instr[6:0] == OPCODE_AUIPC) ? pc : 32'h0;
                d.operand_b = imm_u;
                d.alu_op    = ALU_ADD;
                d.rd_addr   = instr[11:7];
                d.rd_wr_en  = 1'b1;
                d.alu_sel   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // An illegal instruction keeps only its PC so a trap handler can report it.
        if (!legal) begin
            d         = C_DEC_RESET;
            d.pc      = pc;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    logic [63:0] w_head;
    logic        w_full, w_empty;
    logic        w_load, w_bypass, w_push, w_pop, w_sel_valid;
    logic [31:0] w_sel_instr, w_sel_pc;
    logic        dec_valid_q, dec_valid_d;
    decode_t     bundle_q, bundle_d;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i ({instr_addr_i, instr_rdata_i}),
        .rdata_o (w_head),
        .count_o (count_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign instr_ready_o = !w_full;
    assign w_load        = !dec_valid_q || dec_ready_i;
    // Bypass only from an empty buffer, so it can never overtake buffered entries.
    assign w_bypass      = BYPASS_EN && w_empty && instr_valid_i && w_load && !flush_i;
    assign w_push        = instr_valid_i && instr_ready_o && !w_bypass && !flush_i;
    assign w_pop         = w_load && !w_empty && !flush_i;

    assign w_sel_instr = w_empty ? instr_rdata_i : w_head[31:0];
    assign w_sel_pc    = w_empty ? instr_addr_i  : w_head[63:32];
    assign w_sel_valid = !w_empty || w_bypass;
    assign rs1_addr_o  = w_sel_instr[19:15];
    assign rs2_addr_o  = w_sel_instr[24:20];

    always_comb begin
        dec_valid_d = dec_valid_q;
        bundle_d    = bundle_q;
        if (flush_i) begin
            dec_valid_d = 1'b0;
        end else if (w_load) begin
            dec_valid_d = w_sel_valid;
            if (w_sel_valid) bundle_d = decode_instr(w_sel_instr, w_sel_pc, rs1_rdata_i, rs2_rdata_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_valid_q <= 1'b0;
            bundle_q    <= C_DEC_RESET;
        end else begin
            dec_valid_q <= dec_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign dec_valid_o     = dec_valid_q;
    assign dec_pc_o        = bundle_q.pc;
    assign rd_addr_o       = bundle_q.rd_addr;
    assign rd_wr_en_o      = bundle_q.rd_wr_en;
    assign alu_sel_o       = bundle_q.alu_sel;
    assign operand_a_o     = bundle_q.operand_a;
    assign operand_b_o     = bundle_q.operand_b;
    assign alu_operate_o   = bundle_q.alu_op;
    assign lsu_req_o       = bundle_q.lsu_req;
    assign lsu_we_o        = bundle_q.lsu_we;
    assign lsu_operate_o   = bundle_q.lsu_op;
    assign lsu_wdata_o     = bundle_q.lsu_wdata;
    assign illegal_instr_o = bundle_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module  : tb_decode_stage
// Brief   : Directed self-checking bench for decode_stage (DEPTH=4, bypass on).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;
    import milano_pkg::*;

    logic        clk, rst, flush, instr_valid, instr_ready, dec_valid, dec_ready;
    logic [31:0] instr_rdata, instr_addr, rs1_rdata, rs2_rdata;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] dec_pc, operand_a, operand_b, lsu_wdata;
    logic        rd_wr_en, alu_sel, lsu_req, lsu_we, illegal;
    alu_opt_e    alu_op;
    lsu_opt_e    lsu_op;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.DEPTH(4), .BYPASS_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_rdata_i(instr_rdata), .instr_addr_i(instr_addr),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_rdata_i(rs1_rdata), .rs2_rdata_i(rs2_rdata),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .dec_pc_o(dec_pc), .rd_addr_o(rd_addr), .rd_wr_en_o(rd_wr_en),
        .alu_sel_o(alu_sel), .operand_a_o(operand_a), .operand_b_o(operand_b),
        .alu_operate_o(alu_op), .lsu_req_o(lsu_req), .lsu_we_o(lsu_we),
        .lsu_operate_o(lsu_op), .lsu_wdata_o(lsu_wdata),
        .illegal_instr_o(illegal), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        instr_valid = 1'b1;
        instr_rdata = instr;
        instr_addr  = pc;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (alu_op !== ALU_NONE || lsu_op !== LSU_NONE) begin n_fail++; $display("FAIL reset_ops: got alu %0d lsu %0d want 0 0", alu_op, lsu_op); end
        rst = 1'b0;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_bypass();
        dec_ready = 1'b1;
        rs1_rdata = 32'd10;
        instr_valid = 1'b1; instr_rdata = 32'hFFD08293; instr_addr = 32'h100;
        #1;
        n_checks++; if (rs1_addr !== 5'd1) begin n_fail++; $display("FAIL byp_rs1_addr: got %0d want 1", rs1_addr); end
        tick();
        instr_valid = 1'b0;
        n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %b want 1", dec_valid); end
        n_checks++; if (operand_b !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL byp_opb: got %h want fffffffd", operand_b); end
        n_checks++; if (operand_a !== 32'd10) begin n_fail++; $display("FAIL byp_opa: got %h want 0000000a", operand_a); end
        n_checks++; if (alu_op !== ALU_ADD) begin n_fail++; $display("FAIL byp_alu: got %0d want %0d", alu_op, ALU_ADD); end
        n_checks++; if (rd_addr !== 5'd5 || rd_wr_en !== 1'b1 || alu_sel !== 1'b1) begin n_fail++; $display("FAIL byp_rd: got rd %0d we %b sel %b want 5 1 1", rd_addr, rd_wr_en, alu_sel); end
        n_checks++; if (dec_pc !== 32'h100 || count !== 3'd0) begin n_fail++; $display("FAIL byp_pc_count: got pc %h cnt %0d want 100 0", dec_pc, count); end
        tick();
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL byp_drain: got %b want 0", dec_valid); end
    endtask

    task automatic test_store();
        rs1_rdata = 32'h1000; rs2_rdata = 32'hDEADBEEF;
        instr_valid = 1'b1; instr_rdata = 32'hFE712E23; instr_addr = 32'h104;
        #1;
        n_checks++; if (rs2_addr !== 5'd7) begin n_fail++; $display("FAIL sw_rs2_addr: got %0d want 7", rs2_addr); end
        tick();
        instr_valid = 1'b0;
        n_checks++; if (lsu_req !== 1'b1 || lsu_we !== 1'b1 || lsu_op !== LSU_SW) begin n_fail++; $display("FAIL sw_lsu: got req %b we %b op %0d want 1 1 %0d", lsu_req, lsu_we, lsu_op, LSU_SW); end
        n_checks++; if (operand_b !== 32'hFFFFFFFC || operand_a !== 32'h1000) begin n_fail++; $display("FAIL sw_ops: got a %h b %h want 00001000 fffffffc", operand_a, operand_b); end
        n_checks++; if (lsu_wdata !== 32'hDEADBEEF || rd_wr_en !== 1'b0) begin n_fail++; $display("FAIL sw_wdata: got %h we %b want deadbeef 0", lsu_wdata, rd_wr_en); end
        tick();
    endtask

    task automatic test_upper();
        instr_valid = 1'b1; instr_rdata = 32'h12345197; instr_addr = 32'h80;
        tick();
        n_checks++; if (operand_a !== 32'h80 || operand_b !== 32'h12345000) begin n_fail++; $display("FAIL auipc_ops: got a %h b %h want 00000080 12345000", operand_a, operand_b); end
        n_checks++; if (rd_addr !== 5'd3 || alu_op !== ALU_ADD || rd_wr_en !== 1'b1) begin n_fail++; $display("FAIL auipc_ctl: got rd %0d alu %0d we %b want 3 %0d 1", rd_addr, alu_op, rd_wr_en, ALU_ADD); end
        instr_rdata = 32'hABCDE237; instr_addr = 32'h84;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (operand_a !== 32'h0 || operand_b !== 32'hABCDE000 || rd_addr !== 5'd4) begin n_fail++; $display("FAIL lui_ops: got a %h b %h rd %0d want 00000000 abcde000 4", operand_a, operand_b, rd_addr); end
        tick();
    endtask

    task automatic test_illegal();
        instr_valid = 1'b1; instr_rdata = 32'h00000000; instr_addr = 32'h88;
        tick();
        n_checks++; if (dec_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL ill_zero: got v %b ill %b want 1 1", dec_valid, illegal); end
        n_checks++; if (rd_wr_en !== 1'b0 || alu_op !== ALU_NONE || lsu_req !== 1'b0) begin n_fail++; $display("FAIL ill_zero_ctl: got we %b alu %0d req %b want 0 0 0", rd_wr_en, alu_op, lsu_req); end
        instr_rdata = 32'h023100B3; instr_addr = 32'h8C;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (illegal !== 1'b1 || rd_wr_en !== 1'b0 || alu_op !== ALU_NONE || lsu_op !== LSU_NONE) begin n_fail++; $display("FAIL ill_f7: got ill %b we %b alu %0d lsu %0d want 1 0 0 0", illegal, rd_wr_en, alu_op, lsu_op); end
        tick();
    endtask

    task automatic test_backpressure();
        dec_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            push((i << 20) | (i << 7) | 32'h13, 32'h200 + 4 * i);
        n_checks++; if (count !== 3'd4 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got cnt %0d rdy %b want 4 0", count, instr_ready); end
        n_checks++; if (dec_pc !== 32'h204 || rd_addr !== 5'd1) begin n_fail++; $display("FAIL bp_stable: got pc %h rd %0d want 00000204 1", dec_pc, rd_addr); end
        push(32'h00600313, 32'h300);
        n_checks++; if (count !== 3'd4 || dec_pc !== 32'h204) begin n_fail++; $display("FAIL bp_nopush: got cnt %0d pc %h want 4 00000204", count, dec_pc); end
        dec_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'h200 + 4 * k || operand_b !== 32'(k)) begin
                n_fail++;
                $display("FAIL bp_order%0d: got v %b pc %h b %h want 1 %h %h", k, dec_valid, dec_pc, operand_b, 32'h200 + 4 * k, k);
            end
            tick();
        end
        n_checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got v %b cnt %0d want 0 0", dec_valid, count); end
    endtask

    task automatic test_flush();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h00000013, 32'h400 + 4 * i);
        n_checks++; if (count !== 3'd3 || dec_valid !== 1'b1) begin n_fail++; $display("FAIL fl_setup: got cnt %0d v %b want 3 1", count, dec_valid); end
        flush = 1'b1; instr_valid = 1'b1; instr_rdata = 32'h00100093; instr_addr = 32'h500;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %b want 1", instr_ready); end
        tick();
        flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b1;
        n_checks++; if (count !== 3'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL fl_clear: got cnt %0d v %b want 0 0", count, dec_valid); end
        tick();
        n_checks++; if (count !== 3'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL fl_dropped: got cnt %0d v %b want 0 0", count, dec_valid); end
    endtask

    task automatic test_async_reset();
        dec_ready = 1'b0;
        push(32'hFFD08293, 32'h600);
        push(32'h12345197, 32'h604);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL arst_state: got v %b cnt %0d want 0 0", dec_valid, count); end
        n_checks++; if (alu_op !== ALU_NONE || lsu_op !== LSU_NONE || rd_addr !== 5'd0 || operand_b !== 32'h0 || dec_pc !== 32'h0 || rd_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL arst_bundle: got alu %0d lsu %0d rd %0d b %h pc %h we %b want all zero", alu_op, lsu_op, rd_addr, operand_b, dec_pc, rd_wr_en);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", instr_ready); end
        tick();
        n_checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL arst_after: got v %b cnt %0d want 0 0", dec_valid, count); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0;
        instr_rdata = 32'h0; instr_addr = 32'h0; rs1_rdata = 32'h0; rs2_rdata = 32'h0;
        test_reset();
        test_bypass();
        test_store();
        test_upper();
        test_illegal();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
